// File: rtl/sd_sector_writer_if.sv
// Bus bundle between game logic / SD controller and sd_sector_writer.
// The slave modport is the writer's view; master is the driving side.
interface sd_sector_writer_if;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 32;

    logic              fill_we;
    logic [IDX_W-1:0]  fill_addr;
    logic [BYTE_W-1:0] fill_data;
    logic              start;
    logic [ADDR_W-1:0] sector_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  bytes_sent;
    logic              sd_ready;
    logic              sd_ready_for_next_byte;
    logic [ADDR_W-1:0] sd_address;
    logic              sd_wr;
    logic [BYTE_W-1:0] sd_din;

    modport slave (
        input  fill_we, fill_addr, fill_data, start, sector_addr,
        input  sd_ready, sd_ready_for_next_byte,
        output busy, done, err, bytes_sent,
        output sd_address, sd_wr, sd_din
    );

    modport master (
        output fill_we, fill_addr, fill_data, start, sector_addr,
        output sd_ready, sd_ready_for_next_byte,
        input  busy, done, err, bytes_sent,
        input  sd_address, sd_wr, sd_din
    );
endinterface

// File: rtl/sd_sector_writer.sv
// Streams a 512-byte buffer to the SD controller write port as one sector,
// with a watchdog that aborts the operation if the controller stalls.
module sd_sector_writer #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic               clk_spi,
    input  logic               reset_btn,
    sd_sector_writer_if.slave  bus
);
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_WAIT_READY,
        S_ISSUE,
        S_SEND,
        S_WAIT_DONE,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t            state;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  sent_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [BYTE_W-1:0] din_q;
    logic [WD_W-1:0]   wd_q;
    logic              nb_q;
    logic              rdy_q;
    logic [BYTE_W-1:0] rd_data;
    logic [BYTE_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  rd_idx;
    logic              nb_rise;
    logic              rdy_rise;
    logic              wd_expired;

    // Index 512 wraps to 0; that read is never consumed.
    assign rd_idx     = sent_q[IDX_W-1:0];
    assign nb_rise    = bus.sd_ready_for_next_byte & ~nb_q;
    assign rdy_rise   = bus.sd_ready & ~rdy_q;
    assign wd_expired = (wd_q == WD_LAST);

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.bytes_sent = sent_q;
    assign bus.sd_address = addr_q;
    assign bus.sd_wr      = wr_q;
    assign bus.sd_din     = din_q;

    // Sector buffer: fill port is frozen while an operation is in flight.
    always_ff @(posedge clk_spi) begin
        if (bus.fill_we && !busy_q) begin
            mem[bus.fill_addr] <= bus.fill_data;
        end
        rd_data <= mem[rd_idx];
    end

    always_ff @(posedge clk_spi or posedge reset_btn) begin
        if (reset_btn) begin
            nb_q  <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            nb_q  <= bus.sd_ready_for_next_byte;
            rdy_q <= bus.sd_ready;
        end
    end

    always_ff @(posedge clk_spi or posedge reset_btn) begin
        if (reset_btn) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            sent_q <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
            din_q  <= '0;
            wd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q <= bus.sector_addr;
                        err_q  <= 1'b0;
                        sent_q <= '0;
                        busy_q <= 1'b1;
                        wd_q   <= '0;
                        state  <= S_PREFETCH;
                    end
                end
                S_PREFETCH: begin
                    wd_q  <= '0;
                    state <= S_WAIT_READY;
                end
                S_WAIT_READY: begin
                    din_q <= rd_data;
                    if (bus.sd_ready) begin
                        wr_q  <= 1'b1;
                        wd_q  <= '0;
                        state <= S_ISSUE;
                    end else if (wd_expired) begin
                        wd_q  <= '0;
                        state <= S_ERROR;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_ISSUE: begin
                    wd_q  <= '0;
                    state <= S_SEND;
                end
                S_SEND: begin
                    // Read data trails bytes_sent by one cycle, so sd_din settles two cycles after an edge.
                    din_q <= rd_data;
                    if (nb_rise) begin
                        if (sent_q != FULL) begin
                            sent_q <= sent_q + CNT_W'(1);
                        end
                        wd_q <= '0;
                        if (sent_q == LAST_BYTE) begin
                            state <= S_WAIT_DONE;
                        end
                    end else if (wd_expired) begin
                        wd_q  <= '0;
                        state <= S_ERROR;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (rdy_rise) begin
                        wd_q  <= '0;
                        state <= S_FINISH;
                    end else if (wd_expired) begin
                        wd_q  <= '0;
                        state <= S_ERROR;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_FINISH: begin
                    done_q <= 1'b1;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    wd_q   <= '0;
                    state  <= S_IDLE;
                end
                S_ERROR: begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                    busy_q <= 1'b0;
                    wr_q   <= 1'b0;
                    wd_q   <= '0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule
